// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequence generator and its users.
package fib_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int FIB_W = 4;

  // Number of Fibonacci terms (starting at 0) that fit in w bits.
  function automatic int fib_term_count(input int w);
    int a;
    int b;
    int t;
    int n;
    a = 0;
    b = 1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (a < (1 << w)) begin
        n++;
        t = a + b;
        a = b;
        b = t;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: sum of the current and next term, with carry-out
// flagging a sum that no longer fits in WIDTH bits.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             ovf
);

  // Widen by one bit so the carry lands in ovf.
  always_comb begin
    {ovf, s} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Streams Fibonacci terms over a valid/ready handshake, either stopping
// after the largest term that fits in WIDTH bits or wrapping back to 0.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_W,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_wrap,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             b_ovf_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             wrap_reg;

  logic [WIDTH-1:0] sum;
  logic             sum_ovf;
  logic             xfer;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .a   (a_reg),
    .b   (b_reg),
    .s   (sum),
    .ovf (sum_ovf)
  );

  // A term is handed over only while RUN presents it; out_ready never
  // feeds back into the output side combinationally.
  assign xfer = (state_reg == S_RUN) && out_ready;

  // Sequencer: load on start, advance/wrap/finish on transfer, abort on stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= WIDTH'(1);
      b_ovf_reg <= 1'b0;
      idx_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg     <= '0;
            b_reg     <= WIDTH'(1);
            b_ovf_reg <= 1'b0;
            idx_reg   <= '0;
            wrap_reg  <= mode_wrap;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (!b_ovf_reg) begin
              a_reg     <= b_reg;
              b_reg     <= sum;
              b_ovf_reg <= sum_ovf;
              idx_reg   <= idx_reg + IDX_W'(1);
            end else if (wrap_reg) begin
              a_reg     <= '0;
              b_reg     <= WIDTH'(1);
              b_ovf_reg <= 1'b0;
              idx_reg   <= '0;
            end else begin
              state_reg <= S_DONE;
            end
          end
          // Abort wins over DONE: a stopped sequence never reports done.
          if (stop) begin
            state_reg <= S_IDLE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from state/datapath registers.
  always_comb begin
    out_valid = (state_reg == S_RUN);
    busy      = (state_reg == S_RUN);
    done      = (state_reg == S_DONE);
    out_data  = a_reg;
    out_idx   = idx_reg;
    out_last  = b_ovf_reg;
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed scenarios followed by
// random traffic, compared each cycle against a term-table reference model.
module tb_fib_seq_gen;
  import fib_pkg::*;

  localparam int WIDTH = 4;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode_wrap = 1'b0;
  logic             stop = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;
  logic             done;

  fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_wrap (mode_wrap),
    .stop      (stop),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: list of terms plus a position in it.
  int fib_tab[$];
  int n_terms;
  int m_phase;   // 0 idle, 1 streaming, 2 finished pulse
  int m_k;       // position in fib_tab
  bit m_wrap;
  bit m_zero;    // outputs known to be at reset values

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp))
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic cyc(input bit s, input bit mw, input bit sp, input bit rd, input bit r);
    start     = s;
    mode_wrap = mw;
    stop      = sp;
    out_ready = rd;
    rst       = r;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_k     = 0;
      m_wrap  = 1'b0;
      m_zero  = 1'b1;
    end else begin
      case (m_phase)
        0: if (s) begin
             m_phase = 1;
             m_k     = 0;
             m_wrap  = mw;
             m_zero  = 1'b0;
           end
        1: begin
             if (rd) begin
               if (m_k < n_terms - 1) m_k++;
               else if (m_wrap) m_k = 0;
               else m_phase = 2;
             end
             if (sp) m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
    #1;
    chk("valid", 32'(out_valid), (m_phase == 1) ? 1 : 0);
    chk("busy",  32'(busy),      (m_phase == 1) ? 1 : 0);
    chk("done",  32'(done),      (m_phase == 2) ? 1 : 0);
    if (m_phase == 1) begin
      chk("data", 32'(out_data), fib_tab[m_k]);
      chk("idx",  32'(out_idx),  m_k);
      chk("last", 32'(out_last), (m_k == n_terms - 1) ? 1 : 0);
      $display("t=%0t term idx=%0d data=%0d last=%0b ready=%0b", $time, out_idx, out_data, out_last, rd);
    end else if (m_zero) begin
      chk("rst_data", 32'(out_data), 0);
      chk("rst_idx",  32'(out_idx),  0);
      chk("rst_last", 32'(out_last), 0);
    end
  endtask

  initial begin
    int x;
    int y;
    int t;
    x = 0;
    y = 1;
    while (x < (1 << WIDTH)) begin
      fib_tab.push_back(x);
      t = x + y;
      x = y;
      y = t;
    end
    n_terms = fib_tab.size();
    m_phase = 0;
    m_k = 0;
    m_wrap = 1'b0;
    m_zero = 1'b1;

    // Reset state.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 0);   // stop ignored in IDLE

    // Plain non-wrap run, always ready.
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);

    // Non-wrap run with backpressure pattern 1,0,0,1.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0, (i % 4 == 0) || (i % 4 == 3), 0);

    // Wrap mode, 20 transfers, then abort.
    cyc(1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    // Stop coinciding with the transfer of idx 4.
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Reset while term 5 is held under backpressure, then restart.
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);

    // start held high through RUN and DONE; restarts once back in IDLE.
    for (int i = 0; i < 24; i++) cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
